// File: rtl/mdu_pkg.sv
// -----------------------------------------------------------------------------
// mdu_pkg
// Shared definitions for the multi-cycle multiply/divide sequencer:
//   - MDU operation codes (MULT, MULTU, DIV, DIVU)
//   - ALU function codes the sequencer is allowed to request (add, sub)
//   - FSM state encoding
//   - iteration count for the shift-add / restoring-divide loops
//   - small helpers decoding an op code into "is divide" / "is signed"
// -----------------------------------------------------------------------------
package mdu_pkg;

    localparam logic [1:0] MDU_MULT  = 2'b00;
    localparam logic [1:0] MDU_MULTU = 2'b01;
    localparam logic [1:0] MDU_DIV   = 2'b10;
    localparam logic [1:0] MDU_DIVU  = 2'b11;

    localparam logic [5:0] ALU_FUN_ADD = 6'b000000;
    localparam logic [5:0] ALU_FUN_SUB = 6'b000001;

    localparam int ITER_COUNT = 32;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_ITER = 3'd2,
        ST_FIX  = 3'd3
    } mdu_state_t;

    function automatic logic op_is_div(input logic [1:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == MDU_MULT) || (op == MDU_DIV);
    endfunction

endpackage

// File: rtl/mdu_sign_fix.sv
// -----------------------------------------------------------------------------
// mdu_sign_fix
// Combinational conditional two's-complement negation.
//   i_wide = 1 : the 2*W-bit value is negated as one number when i_neg_hi = 1
//                (i_neg_lo ignored) -- used for the 64-bit product.
//   i_wide = 0 : upper and lower W-bit halves are negated independently by
//                i_neg_hi / i_neg_lo -- used for operand abs values and for
//                quotient/remainder.
// Ports:
//   i_wide    in  1     whole-value (1) or split-halves (0) mode
//   i_neg_hi  in  1     negate whole value / upper half
//   i_neg_lo  in  1     negate lower half (split mode only)
//   i_val     in  2*W   value to fix up
//   o_val     out 2*W   fixed-up value
// -----------------------------------------------------------------------------
module mdu_sign_fix #(
    parameter int W = 32
) (
    input  logic           i_wide,
    input  logic           i_neg_hi,
    input  logic           i_neg_lo,
    input  logic [2*W-1:0] i_val,
    output logic [2*W-1:0] o_val
);

    logic [2*W-1:0] w_neg_all;
    logic [W-1:0]   w_neg_hi;
    logic [W-1:0]   w_neg_lo;

    assign w_neg_all = ~i_val + {{(2*W-1){1'b0}}, 1'b1};
    assign w_neg_hi  = ~i_val[2*W-1:W] + {{(W-1){1'b0}}, 1'b1};
    assign w_neg_lo  = ~i_val[W-1:0] + {{(W-1){1'b0}}, 1'b1};

    always_comb begin
        if (i_wide) begin
            o_val = i_neg_hi ? w_neg_all : i_val;
        end else begin
            o_val = {i_neg_hi ? w_neg_hi : i_val[2*W-1:W],
                     i_neg_lo ? w_neg_lo : i_val[W-1:0]};
        end
    end

endmodule

// File: rtl/mdu_seq.sv
// -----------------------------------------------------------------------------
// mdu_seq
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer producing HI/LO. It has no adder of
// its own: every iteration borrows the shared combinational ALU through
// alu_req/alu_gnt, and an iteration only advances on a granted cycle.
// Shift-add multiply and restoring divide each take 32 granted iterations on
// absolute values; signs are restored in the FIX state.
//
// Optional build macro: MDU_DIVZ_FLAG_EN adds output div_zero, high during the
// done pulse of a divide whose divisor was zero.
//
// Ports:
//   clk       in   1   clock
//   reset     in   1   asynchronous active-low reset
//   start     in   1   launch op (sampled only in IDLE)
//   op        in   2   00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   rs_val    in   32  multiplicand / dividend
//   rt_val    in   32  multiplier / divisor
//   busy      out  1   high in every state except IDLE
//   done      out  1   one-cycle pulse, hi/lo valid
//   hi        out  32  product high / remainder
//   lo        out  32  product low / quotient
//   alu_req   out  1   ALU wanted this cycle
//   alu_gnt   in   1   ALU granted this cycle
//   alu_in1   out  32  ALU operand 1 (0 when not requesting)
//   alu_in2   out  32  ALU operand 2 (0 when not requesting)
//   alu_fun   out  6   add or sub
//   alu_sign  out  1   always 0 (unsigned add/sub)
//   alu_out   in   32  ALU result, same cycle
//   div_zero  out  1   (MDU_DIVZ_FLAG_EN only) divide-by-zero flag
// -----------------------------------------------------------------------------
module mdu_seq
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             alu_req,
    input  logic             alu_gnt,
    output logic [WIDTH-1:0] alu_in1,
    output logic [WIDTH-1:0] alu_in2,
    output logic [5:0]       alu_fun,
    output logic             alu_sign,
    input  logic [WIDTH-1:0] alu_out
`ifdef MDU_DIVZ_FLAG_EN
    ,
    output logic             div_zero
`endif
);

    // Control registers
    mdu_state_t       r_state;
    logic             r_busy;
    logic             r_done;
    logic             r_alu_req;
    logic [5:0]       r_cnt;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
`ifdef MDU_DIVZ_FLAG_EN
    logic             r_div_zero;
`endif

    // Datapath registers
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_shreg;
    logic             r_neg_q;
    logic             r_neg_r;

    logic             w_is_div;
    logic             w_is_signed;
    logic [WIDTH-1:0] w_sh;
    logic             w_carry;
    logic             w_borrow;
    logic             w_ok;
    logic             w_divz;
    logic [2*WIDTH-1:0] w_prep;
    logic [2*WIDTH-1:0] w_fix;

    assign w_is_div    = op_is_div(r_op);
    assign w_is_signed = op_is_signed(r_op);

    // Divide shifts the next dividend bit into the partial remainder.
    assign w_sh = {r_acc[WIDTH-2:0], r_shreg[WIDTH-1]};

    // ALU operands are forced to zero whenever no request is outstanding.
    always_comb begin
        alu_in1 = '0;
        alu_in2 = '0;
        alu_fun = ALU_FUN_ADD;
        if (r_alu_req) begin
            if (w_is_div) begin
                alu_in1 = w_sh;
                alu_in2 = r_b;
                alu_fun = ALU_FUN_SUB;
            end else begin
                alu_in1 = r_acc;
                alu_in2 = r_shreg[0] ? r_a : '0;
                alu_fun = ALU_FUN_ADD;
            end
        end
    end

    assign alu_sign = 1'b0;

    // The ALU returns only 32 bits; carry-out and borrow are rebuilt from the
    // operand and result sign bits.
    assign w_carry  = (alu_in1[WIDTH-1] & alu_in2[WIDTH-1]) |
                      ((alu_in1[WIDTH-1] | alu_in2[WIDTH-1]) & ~alu_out[WIDTH-1]);
    assign w_borrow = (~alu_in1[WIDTH-1] & alu_in2[WIDTH-1]) |
                      ((~alu_in1[WIDTH-1] | alu_in2[WIDTH-1]) & alu_out[WIDTH-1]);
    // A set bit shifted out of the remainder means it already exceeds the
    // divisor, so the subtraction always succeeds.
    assign w_ok     = r_acc[WIDTH-1] | ~w_borrow;

    assign w_divz   = w_is_div && (r_b == '0);

    // PREP: absolute values of both operands.
    mdu_sign_fix #(.W(WIDTH)) u_prep_fix (
        .i_wide   (1'b0),
        .i_neg_hi (w_is_signed & r_a[WIDTH-1]),
        .i_neg_lo (w_is_signed & r_b[WIDTH-1]),
        .i_val    ({r_a, r_b}),
        .o_val    (w_prep)
    );

    // FIX: 64-bit negate for products, per-half negate for quotient/remainder.
    mdu_sign_fix #(.W(WIDTH)) u_res_fix (
        .i_wide   (~w_is_div),
        .i_neg_hi (w_is_div ? r_neg_r : r_neg_q),
        .i_neg_lo (r_neg_q),
        .i_val    ({r_acc, r_shreg}),
        .o_val    (w_fix)
    );

    // Sequencer FSM and result registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_alu_req <= 1'b0;
            r_cnt     <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
`ifdef MDU_DIVZ_FLAG_EN
            r_div_zero <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
`ifdef MDU_DIVZ_FLAG_EN
            r_div_zero <= 1'b0;
`endif
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_PREP;
                        r_busy  <= 1'b1;
                    end
                end
                ST_PREP: begin
                    r_state   <= ST_ITER;
                    r_alu_req <= 1'b1;
                    r_cnt     <= '0;
                end
                ST_ITER: begin
                    if (alu_gnt) begin
                        r_cnt <= r_cnt + 6'd1;
                        if (r_cnt == 6'(ITER_COUNT - 1)) begin
                            r_state   <= ST_FIX;
                            r_alu_req <= 1'b0;
                        end
                    end
                end
                ST_FIX: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    // With a zero divisor every step succeeds, so the
                    // remainder naturally returns the original dividend;
                    // only the quotient needs overriding.
                    r_hi <= w_fix[2*WIDTH-1:WIDTH];
                    r_lo <= w_divz ? '1 : w_fix[WIDTH-1:0];
`ifdef MDU_DIVZ_FLAG_EN
                    r_div_zero <= w_divz;
`endif
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_busy    <= 1'b0;
                    r_alu_req <= 1'b0;
                end
            endcase
        end
    end

    // Operand latch and iteration datapath (no reset needed: always loaded
    // before use).
    always_ff @(posedge clk) begin
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    r_op <= op;
                    r_a  <= rs_val;
                    r_b  <= rt_val;
                end
            end
            ST_PREP: begin
                r_a     <= w_prep[2*WIDTH-1:WIDTH];
                r_b     <= w_prep[WIDTH-1:0];
                r_acc   <= '0;
                r_shreg <= w_is_div ? w_prep[2*WIDTH-1:WIDTH] : w_prep[WIDTH-1:0];
                r_neg_q <= w_is_signed & (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
                r_neg_r <= w_is_signed & r_a[WIDTH-1];
            end
            ST_ITER: begin
                if (alu_gnt) begin
                    if (w_is_div) begin
                        r_acc   <= w_ok ? alu_out : w_sh;
                        r_shreg <= {r_shreg[WIDTH-2:0], w_ok};
                    end else begin
                        {r_acc, r_shreg} <= {w_carry, alu_out, r_shreg[WIDTH-1:1]};
                    end
                end
            end
            default: begin
            end
        endcase
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign hi      = r_hi;
    assign lo      = r_lo;
    assign alu_req = r_alu_req;
`ifdef MDU_DIVZ_FLAG_EN
    assign div_zero = r_div_zero;
`endif

endmodule
